// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, the writeback request record and the x0 constant used by the
// register-file writeback arbiter and its divider-result buffer.
package regfile_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int FIFO_W     = REG_ADDR_W + XLEN;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_wb_result_fifo.sv
// Small synchronous FIFO holding divider results ({rd, data}) until the
// register-file write port is free. Head is readable combinationally.
module wb_result_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;

    assign head_data = mem[rd_ptr_reg];
    assign full      = (count_reg == CW'(DEPTH));
    assign empty     = (count_reg == '0);

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owns the register-file write port: the in-order pipeline has priority, out-of-order
// divider results wait in a buffer, and a busy scoreboard stalls decode on hazards.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_wb_valid,
    input  logic [4:0]  pipe_wb_rd,
    input  logic [31:0] pipe_wb_data,
    input  logic        div_issue_valid,
    input  logic [4:0]  div_issue_rd,
    input  logic        div_done_valid,
    input  logic [4:0]  div_done_rd,
    input  logic [31:0] div_done_data,
    output logic        div_done_ready,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic [4:0]  dec_rd,
    output logic        hazard_stall,
    output logic        pipe_hold,
    output logic        regwrite,
    output logic [4:0]  writereg,
    output logic [31:0] writedata
);
    localparam int SCW = $clog2(STARVE_LIMIT + 1);

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FIFO_W-1:0]     head_bits;
    logic [REG_ADDR_W-1:0] head_rd;
    logic [XLEN-1:0]       head_data;
    logic                  pipe_win;
    logic                  push;
    logic                  pop;
    wb_req_t               win_req;

    logic [31:0]           busy_reg;
    logic [31:0]           busy_next;
    logic [SCW-1:0]        starve_cnt_reg;
    logic                  pipe_hold_reg;
    logic                  regwrite_reg;
    logic [REG_ADDR_W-1:0] writereg_reg;
    logic [XLEN-1:0]       writedata_reg;

    assign pipe_win       = pipe_wb_valid && (pipe_wb_rd != ZERO_REG);
    assign push           = div_done_valid && !fifo_full;
    assign pop            = !pipe_win && !fifo_empty;
    assign div_done_ready = !fifo_full;
    assign head_rd        = head_bits[FIFO_W-1:XLEN];
    assign head_data      = head_bits[XLEN-1:0];

    wb_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({div_done_rd, div_done_data}),
        .pop       (pop),
        .head_data (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // A popped x0 result still consumes its slot but never reaches the register file.
    always_comb begin
        win_req = '0;
        if (pipe_win) begin
            win_req = '{valid: 1'b1, rd: pipe_wb_rd, data: pipe_wb_data};
        end else if (pop) begin
            win_req = '{valid: (head_rd != ZERO_REG), rd: head_rd, data: head_data};
        end
    end

    // Issue sets and pop clears; a same-cycle reissue of the retiring rd keeps it busy.
    assign busy_next[0] = 1'b0;
    for (genvar gi = 1; gi < 32; gi++) begin : g_busy
        always_comb begin
            busy_next[gi] = busy_reg[gi];
            if (pop && head_rd == REG_ADDR_W'(gi)) begin
                busy_next[gi] = 1'b0;
            end
            if (div_issue_valid && div_issue_rd == REG_ADDR_W'(gi)) begin
                busy_next[gi] = 1'b1;
            end
        end
    end

    assign hazard_stall = ((dec_rs1 != ZERO_REG) && busy_reg[dec_rs1]) ||
                          ((dec_rs2 != ZERO_REG) && busy_reg[dec_rs2]) ||
                          ((dec_rd  != ZERO_REG) && busy_reg[dec_rd]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwrite_reg   <= 1'b0;
            writereg_reg   <= '0;
            writedata_reg  <= '0;
            busy_reg       <= '0;
            starve_cnt_reg <= '0;
            pipe_hold_reg  <= 1'b0;
        end else begin
            regwrite_reg  <= win_req.valid;
            writereg_reg  <= win_req.rd;
            writedata_reg <= win_req.data;
            busy_reg      <= busy_next;
            pipe_hold_reg <= 1'b0;
            // Non-empty without a pop means the pipeline took the port this cycle.
            if (pop || fifo_empty) begin
                starve_cnt_reg <= '0;
            end else if (starve_cnt_reg == SCW'(STARVE_LIMIT - 1)) begin
                starve_cnt_reg <= '0;
                pipe_hold_reg  <= 1'b1;
            end else begin
                starve_cnt_reg <= starve_cnt_reg + SCW'(1);
            end
        end
    end

    assign regwrite  = regwrite_reg;
    assign writereg  = writereg_reg;
    assign writedata = writedata_reg;
    assign pipe_hold = pipe_hold_reg;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the register file.
- Shares that port between the in-order pipeline writeback stage and the multi-cycle M-extension divider, whose results retire out of order.
- Keeps a busy scoreboard of registers with divides in flight and stalls decode on RAW/WAW hazards against them.
- Sits between the WB stage, the divider and the register file's regwrite/writereg/writedata inputs.

Parameters:
- FIFO_DEPTH, 2, divider-result buffer entries (power of two, ≥2)
- STARVE_LIMIT, 8, consecutive cycles a non-empty buffer may lose arbitration before the pipeline is held

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- pipe_wb_valid  input  1  pipeline writeback request
- pipe_wb_rd  input  5  pipeline destination register
- pipe_wb_data  input  32  pipeline writeback data
- div_issue_valid  input  1  divide launched this cycle
- div_issue_rd  input  5  destination of launched divide
- div_done_valid  input  1  divider result available
- div_done_rd  input  5  divider result destination
- div_done_data  input  32  divider result
- div_done_ready  output  1  buffer can accept result (= not full)
- dec_rs1  input  5  decode-stage source 1
- dec_rs2  input  5  decode-stage source 2
- dec_rd  input  5  decode-stage destination
- hazard_stall  output  1  decode must stall
- pipe_hold  output  1  pipeline must freeze WB for one cycle
- regwrite  output  1  to register file
- writereg  output  5  to register file
- writedata  output  32  to register file

Behaviour:
- Reset (async, rst=1):
  - regwrite=0, writereg=0, writedata=0, pipe_hold=0.
  - busy=0, buffer empty, starvation counter=0.
  - Hence div_done_ready=1 and hazard_stall=0.
- Latency: one cycle. regwrite/writereg/writedata are registered at the rising edge, one cycle after the winning request.
- Arbitration each cycle:
  - Pipeline wins when pipe_wb_valid=1 and pipe_wb_rd≠0.
  - Otherwise the buffer head is popped if the buffer is non-empty.
  - Otherwise regwrite=0.
  - pipe_wb_rd=0 counts as a free slot; x0 is never written.
- Buffer:
  - FIFO, push on div_done_valid & div_done_ready.
  - Push and pop in the same cycle are allowed; pushing while full is prohibited.
  - A push to an empty buffer cannot pop in the same cycle; the earliest write is two cycles after div_done_valid.
  - Pointers wrap modulo FIFO_DEPTH.
- Divider entries with div_done_rd=0 are discarded at pop: slot consumed, regwrite=0.
- Scoreboard busy[31:1]:
  - Set busy[div_issue_rd] on div_issue_valid when rd≠0.
  - Clear busy[writereg] on the edge that registers a buffer pop.
  - Simultaneous set and clear of the same index: set wins.
- hazard_stall (combinational from registered busy) = busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd], each term qualified by index≠0.
- Consequence: the pipeline never writes a busy rd. A pipeline write to a busy rd is a protocol violation and is flagged by a bench assertion.
- Starvation:
  - Counter increments each cycle the buffer is non-empty and the pipeline wins.
  - Counter resets on any pop or when the buffer is empty.
  - When it reaches STARVE_LIMIT, pipe_hold=1 is registered for exactly one cycle and the counter clears.
  - While pipe_hold=1 the pipeline guarantees pipe_wb_valid=0, so the head pops.
- Reset mid-operation: buffered results and busy bits are lost. The core flushes the divider with the same rst.

Decomposition:
- Shared package: REG_ADDR_W=5, XLEN=32, a wb_req struct {valid, rd, data}, and the ZERO_REG constant.
- One natural sub-module: wb_result_fifo, a parameterised FIFO_DEPTH×37-bit synchronous FIFO with full/empty flags and async reset. Arbitration, scoreboard and starvation logic stay in the top.

Test Plan:
- Reset:
  - Stimulus: assert rst mid-cycle with 1 buffered entry.
  - Required response: all outputs zero immediately, div_done_ready=1, busy cleared.
- Single divide:
  - Stimulus: issue rd=5; done rd=5 data=0xDEADBEEF 10 cycles later; pipeline idle.
  - Required response:
    - hazard_stall=1 for dec_rs1=5 from the cycle after issue.
    - regwrite=1, writereg=5, writedata=0xDEADBEEF two cycles after done.
    - Stall drops the following cycle.
- Priority:
  - Stimulus: pipe_wb rd=3 data=7 in the same cycle as div done rd=9.
  - Required response: reg 3 written first; reg 9 written in the next idle cycle.
- Full/backpressure:
  - Stimulus: continuous pipeline writes with rd≠0 and 3 divider completions.
  - Required response: div_done_ready=0 after 2 pushes; third held until a pop.
- Starvation:
  - Stimulus: pipeline writes every cycle with one buffered entry.
  - Required response: pipe_hold=1 for exactly one cycle after 8 lost cycles; entry written during the hold.
- x0 cases:
  - Stimulus: div issue rd=0; done rd=0; pipeline rd=0 with data=1.
  - Required response: busy never set, regwrite never asserted for x0, slot reused by the buffer head.
